id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the 5-stage MIPS core, with load-use hazard detection and bubble insertion.
- Sits directly upstream of the forwarding unit. Its registered ex_rs/ex_rt feed the forwarding unit's ID/EX rs/rt inputs. Its ex_dst travels on to become the EX/MEM and MEM/WB destination numbers.
- Produces stall_o back to PC and IF/ID so the forwarding unit never sees a load result it cannot forward.

Parameters:
- DW, 32, data path width
- RW, 5, register-number width
- CTRL_W, 9, packed control bus width; field layout is defined in the package

Ports:
- clock  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID stage holds a real instruction
- id_op  in  6  opcode
- id_rs  in  RW  source register number rs
- id_rt  in  RW  source register number rt
- id_rd  in  RW  destination register number rd
- id_uses_rt  in  1  instruction reads rt as a source (R-type, branch, store)
- id_rs_val  in  DW  register-file read data for rs
- id_rt_val  in  DW  register-file read data for rt
- id_imm  in  DW  sign-extended immediate
- id_ctrl  in  CTRL_W  {regwrite, memtoreg, memread, memwrite, branch, alusrc, regdst, aluop[1:0]}
- flush  in  1  branch/jump redirect; kill the instruction currently in ID
- mem_busy  in  1  data memory not ready; freeze the whole pipe
- stall_o  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  registered copy of id_valid
- ex_op  out  6  registered opcode
- ex_rs  out  RW  registered rs
- ex_rt  out  RW  registered rt
- ex_dst  out  RW  registered destination: rd when regdst=1, else rt
- ex_rs_val  out  DW  registered rs data
- ex_rt_val  out  DW  registered rt data
- ex_imm  out  DW  registered immediate
- ex_ctrl  out  CTRL_W  registered control bus

Behaviour:
- Reset (asynchronous, reset_n=0):
  - all ex_* outputs go to 0 and the FSM goes to RUN.
  - stall_o is 0 while in reset.
  - Reset mid-stall or mid-freeze aborts the stall or freeze immediately.
- Bubble definition: ex_valid=0, ex_ctrl=0, ex_op=0, ex_rs=ex_rt=ex_dst=0; data fields are don't-care and driven to 0. A bubble therefore never matches any forwarding compare, because r0 is excluded.
- load_use (combinational) = ex_ctrl.memread & ex_rt!=0 & id_valid & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- FSM states:
  - RUN: normal flow.
  - BUBBLE: one cycle following a load-use stall.
  - FREEZE: memory wait.
- Priority at each posedge: mem_busy > flush > load_use > normal load.
- mem_busy=1:
  - all registers hold; stall_o=1.
  - FSM enters FREEZE, remembering the prior state (RUN or BUBBLE).
  - On release it returns to that state.
  - flush and load_use are ignored while frozen; the producer holds flush until mem_busy drops.
- flush=1 with mem_busy=0: load a bubble; stall_o=0; next state RUN. This applies even if load_use is also true.
- RUN with load_use=1:
  - stall_o=1 in the same cycle, combinationally.
  - next edge loads a bubble; next state BUBBLE.
  - IF/ID holds, so the dependent instruction is re-presented.
- BUBBLE: hazard check is suppressed and stall_o=0; the instruction in ID loads normally; next state RUN. This guarantees exactly one bubble per load-use, with the load result then reaching the dependent instruction through MEM/WB forwarding.
- Normal load:
  - every ex_* output takes its id_* counterpart.
  - ex_dst = id_ctrl.regdst ? id_rd : id_rt.
  - If id_valid=0, a bubble is loaded instead.
- Latency: 1 cycle from ID inputs to ex_* outputs. No combinational path from ID inputs to ex_* outputs.
- Back-to-back loads with dependent consumers each insert exactly one bubble.

Optional Feature:
- HAZARD_STATS_EN defined adds two output ports:
  - bubble_cnt[31:0]: counts load-use bubbles inserted.
  - freeze_cnt[31:0]: counts cycles with mem_busy=1.
  - Both reset to 0 and wrap at 2^32 with no saturation.
- Without the macro: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package mips_pkg holds:
  - ctrl_t packed struct and the CTRL_W field-index constants.
  - FSM state enum {RUN, BUBBLE, FREEZE}.
  - REG_ZERO constant.
  - opcode constants OP_RTYPE=6'h00, OP_LW=6'h23, OP_SW=6'h2B, OP_BEQ=6'h04.
- One sub-module, load_use_detect, is the purely combinational load_use equation, reused later by the branch-in-ID hazard logic.

Test Plan:
- Reset: with reset_n=0 mid-operation, all ex_* outputs=0 and stall_o=0 asynchronously, before any clock edge.
- Load-use: lw $8,0($1) followed by add $9,$8,$2 → stall_o=1 for one cycle; the next cycle holds a bubble (ex_valid=0, ex_dst=0); then the add appears with ex_rs=8; stall_o stays 0 in BUBBLE.
- No hazard on r0: lw $0 followed by add $9,$0,$2 → no stall.
- No hazard on unused rt: lw $8 followed by addi $9,$3,4 with id_rt=8 and id_uses_rt=0 → no stall.
- Flush beats load-use: flush=1 in the same cycle as load_use=1 → bubble loaded, stall_o=0, FSM in RUN.
- Freeze: mem_busy=1 for 3 cycles while in BUBBLE → outputs hold for 3 cycles; FSM resumes in BUBBLE; with HAZARD_STATS_EN, freeze_cnt=3 and bubble_cnt=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: control-bus layout, hazard FSM states and opcodes.
package mips_pkg;

  localparam int CTRL_WIDTH    = 9;
  localparam int CTRL_REGWRITE = 8;
  localparam int CTRL_MEMTOREG = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_BRANCH   = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_REGDST   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       alusrc;
    logic       regdst;
    logic [1:0] aluop;
  } ctrl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    FREEZE = 2'd2
  } stage_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // Destination register selection shared by every stage that resolves writeback targets.
  function automatic logic [4:0] pick_dst(input ctrl_t c, input logic [4:0] rd, input logic [4:0] rt);
    return c.regdst ? rd : rt;
  endfunction

endpackage

// File: rtl/id_ex_stage_load_use_detect.sv
// Combinational load-use detector: a load in EX whose target is read by the instruction in ID.
module load_use_detect
  import mips_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          ex_memread_i,
  input  logic [RW-1:0] ex_rt_i,
  input  logic          id_valid_i,
  input  logic [RW-1:0] id_rs_i,
  input  logic [RW-1:0] id_rt_i,
  input  logic          id_uses_rt_i,
  output logic          load_use_o
);

  logic rt_live;
  logic rs_match;
  logic rt_match;

  // r0 is hard-wired zero, so a load targeting it can never create a dependency.
  assign rt_live    = (ex_rt_i != RW'(REG_ZERO));
  assign rs_match   = (ex_rt_i == id_rs_i);
  assign rt_match   = id_uses_rt_i & (ex_rt_i == id_rt_i);
  assign load_use_o = ex_memread_i & rt_live & id_valid_i & (rs_match | rt_match);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubbles and memory freeze.
// Optional hazard counters are built when HAZARD_STATS_EN is defined.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW     = 32,
  parameter int RW     = 5,
  parameter int CTRL_W = 9
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [5:0]        id_op,
  input  logic [RW-1:0]     id_rs,
  input  logic [RW-1:0]     id_rt,
  input  logic [RW-1:0]     id_rd,
  input  logic              id_uses_rt,
  input  logic [DW-1:0]     id_rs_val,
  input  logic [DW-1:0]     id_rt_val,
  input  logic [DW-1:0]     id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic              mem_busy,
  output logic              stall_o,
  output logic              ex_valid,
  output logic [5:0]        ex_op,
  output logic [RW-1:0]     ex_rs,
  output logic [RW-1:0]     ex_rt,
  output logic [RW-1:0]     ex_dst,
  output logic [DW-1:0]     ex_rs_val,
  output logic [DW-1:0]     ex_rt_val,
  output logic [DW-1:0]     ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]       bubble_cnt,
  output logic [31:0]       freeze_cnt
`endif
);

  stage_state_e state_q;
  stage_state_e resume_q;
  stage_state_e active_state;

  logic              ex_valid_q,  ex_valid_d;
  logic [5:0]        ex_op_q,     ex_op_d;
  logic [RW-1:0]     ex_rs_q,     ex_rs_d;
  logic [RW-1:0]     ex_rt_q,     ex_rt_d;
  logic [RW-1:0]     ex_dst_q,    ex_dst_d;
  logic [DW-1:0]     ex_rs_val_q, ex_rs_val_d;
  logic [DW-1:0]     ex_rt_val_q, ex_rt_val_d;
  logic [DW-1:0]     ex_imm_q,    ex_imm_d;
  logic [CTRL_W-1:0] ex_ctrl_q,   ex_ctrl_d;

  ctrl_t id_ctrl_s;
  ctrl_t ex_ctrl_s;
  logic  load_use;
  logic  hazard;
  logic  kill;

  assign id_ctrl_s = id_ctrl[CTRL_WIDTH-1:0];
  assign ex_ctrl_s = ex_ctrl_q[CTRL_WIDTH-1:0];

  load_use_detect #(
    .RW (RW)
  ) u_load_use (
    .ex_memread_i (ex_ctrl_s.memread),
    .ex_rt_i      (ex_rt_q),
    .id_valid_i   (id_valid),
    .id_rs_i      (id_rs),
    .id_rt_i      (id_rt),
    .id_uses_rt_i (id_uses_rt),
    .load_use_o   (load_use)
  );

  // FREEZE is transparent: once memory releases, the cycle behaves as the state it interrupted.
  assign active_state = (state_q == FREEZE) ? resume_q : state_q;
  assign hazard       = load_use & (active_state == RUN);
  assign stall_o      = reset_n & (mem_busy | (~flush & hazard));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= RUN;
      resume_q <= RUN;
    end else if (mem_busy) begin
      state_q  <= FREEZE;
      resume_q <= active_state;
    end else if (!flush && hazard) begin
      state_q  <= BUBBLE;
    end else begin
      state_q  <= RUN;
    end
  end

  // A flush, a load-use stall or an empty ID slot all become a fully zeroed bubble.
  always_comb begin
    kill        = flush | hazard | ~id_valid;
    ex_valid_d  = 1'b0;
    ex_op_d     = '0;
    ex_rs_d     = '0;
    ex_rt_d     = '0;
    ex_dst_d    = '0;
    ex_rs_val_d = '0;
    ex_rt_val_d = '0;
    ex_imm_d    = '0;
    ex_ctrl_d   = '0;
    if (!kill) begin
      ex_valid_d  = 1'b1;
      ex_op_d     = id_op;
      ex_rs_d     = id_rs;
      ex_rt_d     = id_rt;
      ex_dst_d    = id_ctrl_s.regdst ? id_rd : id_rt;
      ex_rs_val_d = id_rs_val;
      ex_rt_val_d = id_rt_val;
      ex_imm_d    = id_imm;
      ex_ctrl_d   = id_ctrl;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ex_valid_q  <= 1'b0;
      ex_op_q     <= '0;
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_dst_q    <= '0;
      ex_rs_val_q <= '0;
      ex_rt_val_q <= '0;
      ex_imm_q    <= '0;
      ex_ctrl_q   <= '0;
    end else if (!mem_busy) begin
      ex_valid_q  <= ex_valid_d;
      ex_op_q     <= ex_op_d;
      ex_rs_q     <= ex_rs_d;
      ex_rt_q     <= ex_rt_d;
      ex_dst_q    <= ex_dst_d;
      ex_rs_val_q <= ex_rs_val_d;
      ex_rt_val_q <= ex_rt_val_d;
      ex_imm_q    <= ex_imm_d;
      ex_ctrl_q   <= ex_ctrl_d;
    end
  end

  assign ex_valid  = ex_valid_q;
  assign ex_op     = ex_op_q;
  assign ex_rs     = ex_rs_q;
  assign ex_rt     = ex_rt_q;
  assign ex_dst    = ex_dst_q;
  assign ex_rs_val = ex_rs_val_q;
  assign ex_rt_val = ex_rt_val_q;
  assign ex_imm    = ex_imm_q;
  assign ex_ctrl   = ex_ctrl_q;

`ifdef HAZARD_STATS_EN
  logic [31:0] bubble_cnt_q;
  logic [31:0] freeze_cnt_q;

  // Counters wrap freely; only edges that actually insert a load-use bubble are counted as bubbles.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt_q <= '0;
      freeze_cnt_q <= '0;
    end else if (mem_busy) begin
      freeze_cnt_q <= freeze_cnt_q + 32'd1;
    end else if (!flush && hazard) begin
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign bubble_cnt = bubble_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard scenarios followed by random traffic
// checked against a rule-level reference model.
module tb_id_ex_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 9;

  typedef struct packed {
    logic          valid;
    logic [5:0]    op;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [RW-1:0] dst;
    logic [DW-1:0] rsVal;
    logic [DW-1:0] rtVal;
    logic [DW-1:0] imm;
    logic [CW-1:0] ctrl;
  } ex_t;

  logic          clock;
  logic          reset_n;
  logic          idValid;
  logic [5:0]    idOp;
  logic [RW-1:0] idRs, idRt, idRd;
  logic          idUsesRt;
  logic [DW-1:0] idRsVal, idRtVal, idImm;
  logic [CW-1:0] idCtrl;
  logic          flushIn;
  logic          busyIn;
  logic          stall_o;
  logic          exValid;
  logic [5:0]    exOp;
  logic [RW-1:0] exRs, exRt, exDst;
  logic [DW-1:0] exRsVal, exRtVal, exImm;
  logic [CW-1:0] exCtrl;
`ifdef HAZARD_STATS_EN
  logic [31:0]   bubbleCnt, freezeCnt;
`endif

  int   checks = 0;
  int   failures = 0;
  ex_t  m;
  bit   afterStall;
  logic stallSeen;
  int   bubbleCount;
  int   freezeCount;

  localparam logic [CW-1:0] CTRL_LW  = 9'h1C8;
  localparam logic [CW-1:0] CTRL_ADD = 9'h106;
  localparam logic [CW-1:0] CTRL_ADDI = 9'h108;

  id_ex_stage #(.DW(DW), .RW(RW), .CTRL_W(CW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .id_valid   (idValid),
    .id_op      (idOp),
    .id_rs      (idRs),
    .id_rt      (idRt),
    .id_rd      (idRd),
    .id_uses_rt (idUsesRt),
    .id_rs_val  (idRsVal),
    .id_rt_val  (idRtVal),
    .id_imm     (idImm),
    .id_ctrl    (idCtrl),
    .flush      (flushIn),
    .mem_busy   (busyIn),
    .stall_o    (stall_o),
    .ex_valid   (exValid),
    .ex_op      (exOp),
    .ex_rs      (exRs),
    .ex_rt      (exRt),
    .ex_dst     (exDst),
    .ex_rs_val  (exRsVal),
    .ex_rt_val  (exRtVal),
    .ex_imm     (exImm),
    .ex_ctrl    (exCtrl)
`ifdef HAZARD_STATS_EN
    ,
    .bubble_cnt (bubbleCnt),
    .freeze_cnt (freezeCnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic ex_t dutBundle();
    return {exValid, exOp, exRs, exRt, exDst, exRsVal, exRtVal, exImm, exCtrl};
  endfunction

  // The instruction in ID needs the value a load in EX has not fetched yet.
  function automatic bit modelLoadUse();
    return m.ctrl[6] && (m.rt != 0) && idValid &&
           ((m.rt == idRs) || (idUsesRt && (m.rt == idRt)));
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [5:0] op, input logic [RW-1:0] rs,
                               input logic [RW-1:0] rt, input logic [RW-1:0] rd, input logic usesRt,
                               input logic [CW-1:0] ctrl, input logic fl, input logic busy);
    idValid  = v;
    idOp     = op;
    idRs     = rs;
    idRt     = rt;
    idRd     = rd;
    idUsesRt = usesRt;
    idRsVal  = $urandom;
    idRtVal  = $urandom;
    idImm    = $urandom;
    idCtrl   = ctrl;
    flushIn  = fl;
    busyIn   = busy;
  endtask

  // One clock: check the combinational stall before the edge, the registered bundle after it.
  task automatic runCycle(input string tag);
    ex_t nextM;
    bit  nextAfter;
    bit  expStall;
    @(negedge clock);
    expStall  = busyIn || (!flushIn && !afterStall && modelLoadUse());
    stallSeen = stall_o;
    checkOutput({tag, "_stall"}, 128'(stall_o), 128'(expStall));
    nextM     = m;
    nextAfter = afterStall;
    if (busyIn) begin
      freezeCount++;
    end else if (flushIn) begin
      nextM = '0;
      nextAfter = 1'b0;
    end else if (!afterStall && modelLoadUse()) begin
      nextM = '0;
      nextAfter = 1'b1;
      bubbleCount++;
    end else begin
      nextAfter = 1'b0;
      if (idValid)
        nextM = {1'b1, idOp, idRs, idRt, (idCtrl[2] ? idRd : idRt), idRsVal, idRtVal, idImm, idCtrl};
      else
        nextM = '0;
    end
    @(posedge clock);
    m = nextM;
    afterStall = nextAfter;
    #1;
    checkOutput({tag, "_ex"}, 128'(dutBundle()), 128'(m));
  endtask

  task automatic applyReset(input string tag);
    #1 reset_n = 1'b0;
    #1;
    checkOutput({tag, "_rst_stall"}, 128'(stall_o), 128'(0));
    checkOutput({tag, "_rst_ex"}, 128'(dutBundle()), 128'(0));
    @(posedge clock);
    #1 reset_n = 1'b1;
    m = '0;
    afterStall = 1'b0;
    bubbleCount = 0;
    freezeCount = 0;
  endtask

  function automatic logic [RW-1:0] pickReg();
    case ($urandom_range(0, 4))
      0:       return 5'd0;
      1:       return 5'd1;
      2:       return 5'd2;
      3:       return 5'd8;
      default: return 5'd9;
    endcase
  endfunction

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, '0, 1'b0, 1'b0);
    m = '0;
    afterStall = 1'b0;
    bubbleCount = 0;
    freezeCount = 0;
    #1;
    checkOutput("por_stall", 128'(stall_o), 128'(0));
    checkOutput("por_ex", 128'(dutBundle()), 128'(0));
    @(posedge clock);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // lw $8,0($1) then add $9,$8,$2: one stall, one bubble, then the add.
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd8, 5'd0, 1'b0, CTRL_LW, 1'b0, 1'b0);
    runCycle("lu_lw");
    checkOutput("lu_lw_dst", 128'(exDst), 128'(8));
    applyStimulus(1'b1, 6'h00, 5'd8, 5'd2, 5'd9, 1'b1, CTRL_ADD, 1'b0, 1'b0);
    runCycle("lu_add1");
    checkOutput("lu_stall_hi", 128'(stallSeen), 128'(1));
    checkOutput("lu_bubble_valid", 128'(exValid), 128'(0));
    checkOutput("lu_bubble_dst", 128'(exDst), 128'(0));
    runCycle("lu_add2");
    checkOutput("lu_bubble_nostall", 128'(stallSeen), 128'(0));
    checkOutput("lu_add_rs", 128'(exRs), 128'(8));
    checkOutput("lu_add_dst", 128'(exDst), 128'(9));

    // Load into r0 never stalls.
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd0, 5'd0, 1'b0, CTRL_LW, 1'b0, 1'b0);
    runCycle("r0_lw");
    applyStimulus(1'b1, 6'h00, 5'd0, 5'd2, 5'd9, 1'b1, CTRL_ADD, 1'b0, 1'b0);
    runCycle("r0_add");
    checkOutput("r0_nostall", 128'(stallSeen), 128'(0));

    // addi $9,$3,4 carries rt=8 but does not read it.
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd8, 5'd0, 1'b0, CTRL_LW, 1'b0, 1'b0);
    runCycle("urt_lw");
    applyStimulus(1'b1, 6'h08, 5'd3, 5'd8, 5'd0, 1'b0, CTRL_ADDI, 1'b0, 1'b0);
    runCycle("urt_addi");
    checkOutput("urt_nostall", 128'(stallSeen), 128'(0));
    checkOutput("urt_dst", 128'(exDst), 128'(8));

    // Flush in the same cycle as a load-use hazard wins.
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd8, 5'd0, 1'b0, CTRL_LW, 1'b0, 1'b0);
    runCycle("fl_lw");
    applyStimulus(1'b1, 6'h00, 5'd8, 5'd2, 5'd9, 1'b1, CTRL_ADD, 1'b1, 1'b0);
    runCycle("fl_add");
    checkOutput("fl_nostall", 128'(stallSeen), 128'(0));
    checkOutput("fl_bubble", 128'(exValid), 128'(0));

    // Asynchronous reset while a stall is being requested.
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd8, 5'd0, 1'b0, CTRL_LW, 1'b0, 1'b0);
    runCycle("mr_lw");
    applyStimulus(1'b1, 6'h00, 5'd8, 5'd2, 5'd9, 1'b1, CTRL_ADD, 1'b0, 1'b0);
    #1;
    checkOutput("mr_stall_pre", 128'(stall_o), 128'(1));
    applyReset("mr");

    // Freeze for three cycles while sitting in the post-stall bubble.
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd8, 5'd0, 1'b0, CTRL_LW, 1'b0, 1'b0);
    runCycle("fz_lw");
    applyStimulus(1'b1, 6'h00, 5'd8, 5'd2, 5'd9, 1'b1, CTRL_ADD, 1'b0, 1'b0);
    runCycle("fz_stall");
    busyIn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      runCycle("fz_hold");
      checkOutput("fz_hold_stall", 128'(stallSeen), 128'(1));
      checkOutput("fz_hold_valid", 128'(exValid), 128'(0));
    end
    busyIn = 1'b0;
    runCycle("fz_resume");
    checkOutput("fz_resume_nostall", 128'(stallSeen), 128'(0));
    checkOutput("fz_resume_rs", 128'(exRs), 128'(8));
`ifdef HAZARD_STATS_EN
    checkOutput("fz_freeze_cnt", 128'(freezeCnt), 128'(3));
    checkOutput("fz_bubble_cnt", 128'(bubbleCnt), 128'(1));
`endif

    // Back-to-back dependent loads each cost exactly one bubble.
    applyStimulus(1'b1, 6'h23, 5'd1, 5'd8, 5'd0, 1'b0, CTRL_LW, 1'b0, 1'b0);
    runCycle("bb_lw1");
    applyStimulus(1'b1, 6'h23, 5'd8, 5'd9, 5'd0, 1'b0, CTRL_LW, 1'b0, 1'b0);
    runCycle("bb_lw2a");
    checkOutput("bb_stall1", 128'(stallSeen), 128'(1));
    runCycle("bb_lw2b");
    checkOutput("bb_lw2_dst", 128'(exDst), 128'(9));
    applyStimulus(1'b1, 6'h00, 5'd9, 5'd2, 5'd10, 1'b1, CTRL_ADD, 1'b0, 1'b0);
    runCycle("bb_adda");
    checkOutput("bb_stall2", 128'(stallSeen), 128'(1));
    runCycle("bb_addb");
    checkOutput("bb_add_dst", 128'(exDst), 128'(10));

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 9) != 0), 6'($urandom), pickReg(), pickReg(), pickReg(),
                    1'($urandom), (($urandom_range(0, 2) == 0) ? CTRL_LW : 9'($urandom)),
                    ($urandom_range(0, 9) == 0), ($urandom_range(0, 6) == 0));
      runCycle("rnd");
    end
`ifdef HAZARD_STATS_EN
    checkOutput("rnd_freeze_cnt", 128'(freezeCnt), 128'(freezeCount));
    checkOutput("rnd_bubble_cnt", 128'(bubbleCnt), 128'(bubbleCount));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
